// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   WIDTH    operand width (only 32 is supported; HiLo is 2*WIDTH)
//   ITER     iterations per operation (equals WIDTH, one bit per cycle)
//   opCode_t MULT / MULTU / DIV / DIVU encodings as presented by EX
//   state_t  sequencer states
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } opCode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    function automatic logic opIsDiv(input opCode_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic opIsSigned(input opCode_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Handshake and result bundle between the EX stage (master) and the muldiv
// sequencer (slave).
//   Start       EX holds a valid muldiv instruction this cycle
//   Flush       EX instruction is squashed (qualifies Start)
//   Op          operation code (see muldiv_pkg::opCode_t)
//   OpA, OpB    forwarded rs / rt values
//   HiLoAccess  EX instruction is mfhi, mflo, mthi or mtlo
//   Stall       hold PC, IF/ID and ID/EX; bubble into EX/MEM
//   Busy        sequencer is not idle
//   HiLoEn      one-cycle HiLo write strobe
//   HiLoWrite   result as {Hi, Lo}
//   DivByZero   divide had a zero divisor (valid with HiLoEn)
// -----------------------------------------------------------------------------
interface muldiv_if;
    import muldiv_pkg::*;

    logic                 Start;
    logic                 Flush;
    logic [1:0]           Op;
    logic [WIDTH-1:0]     OpA;
    logic [WIDTH-1:0]     OpB;
    logic                 HiLoAccess;
    logic                 Stall;
    logic                 Busy;
    logic                 HiLoEn;
    logic [2*WIDTH-1:0]   HiLoWrite;
    logic                 DivByZero;

    modport master (
        output Start, Flush, Op, OpA, OpB, HiLoAccess,
        input  Stall, Busy, HiLoEn, HiLoWrite, DivByZero
    );

    modport slave (
        input  Start, Flush, Op, OpA, OpB, HiLoAccess,
        output Stall, Busy, HiLoEn, HiLoWrite, DivByZero
    );

endinterface

// File: rtl/muldiv_core.sv
// -----------------------------------------------------------------------------
// muldiv_core
// Iterative datapath: shift-add multiply and restoring divide, one bit per
// step, operating on magnitudes, followed by a single sign-fixup cycle.
//   Clock     system clock, rising edge
//   load      capture operands (magnitudes, signs, zero-divisor flag)
//   step      perform one iteration
//   fix       apply sign fixup / divide-by-zero result
//   isDiv     operation is a divide (sampled with load)
//   isSigned  operation is signed (sampled with load)
//   opA, opB  raw operands
//   result    {Hi, Lo}: product, or {remainder, quotient}
//   divZero   captured divisor was zero on a divide
// Datapath registers carry no reset; the sequencer gates what leaves the block.
// -----------------------------------------------------------------------------
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic                 Clock,
    input  logic                 load,
    input  logic                 step,
    input  logic                 fix,
    input  logic                 isDiv,
    input  logic                 isSigned,
    input  logic [WIDTH-1:0]     opA,
    input  logic [WIDTH-1:0]     opB,
    output logic [2*WIDTH-1:0]   result,
    output logic                 divZero
);

    localparam int W = WIDTH;

    // acc holds {product_hi, multiplier/product_lo} for multiply and
    // {remainder, dividend/quotient} for divide.
    logic [2*W-1:0] acc;
    logic [W-1:0]   operand;     // multiplicand or divisor magnitude
    logic [W-1:0]   origA;       // unmodified dividend, returned as Hi on /0
    logic           divMode;
    logic           negMain;     // negate product or quotient
    logic           negRem;      // remainder follows dividend sign
    logic           zeroDivisor;

    logic [W:0]     mulSum;
    logic [W:0]     remShift;
    logic [W:0]     trial;

    // Magnitude of a signed value; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude 2^31.
    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v,
                                               input logic useSign);
        logic signed [W-1:0] negV;
        negV = -v;
        return (useSign && v[W-1]) ? negV : v;
    endfunction

    function automatic logic [W-1:0] negWord(input logic [W-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [2*W-1:0] negDword(input logic [2*W-1:0] v);
        return ~v + 1'b1;
    endfunction

    // Carry out of the upper half is kept: it becomes the new MSB on shift.
    assign mulSum   = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
    // Remainder after the left shift can reach W+1 bits before the trial.
    assign remShift = acc[2*W-1:W-1];
    assign trial    = remShift - {1'b0, operand};

    always_ff @(posedge Clock) begin
        if (load) begin
            divMode     <= isDiv;
            negMain     <= isSigned & (opA[W-1] ^ opB[W-1]);
            negRem      <= isSigned & opA[W-1];
            zeroDivisor <= isDiv & (opB == '0);
            origA       <= opA;
            if (isDiv) begin
                acc     <= {{W{1'b0}}, magnitude(opA, isSigned)};
                operand <= magnitude(opB, isSigned);
            end else begin
                acc     <= {{W{1'b0}}, magnitude(opB, isSigned)};
                operand <= magnitude(opA, isSigned);
            end
        end else if (step) begin
            if (divMode) begin
                if (!trial[W]) begin
                    acc <= {trial[W-1:0], acc[W-2:0], 1'b1};
                end else begin
                    acc <= {acc[2*W-2:0], 1'b0};
                end
            end else begin
                if (acc[0]) begin
                    acc <= {mulSum, acc[W-1:1]};
                end else begin
                    acc <= {1'b0, acc[2*W-1:1]};
                end
            end
        end else if (fix) begin
            if (divMode) begin
                if (zeroDivisor) begin
                    acc <= {origA, {W{1'b1}}};
                end else begin
                    acc[2*W-1:W] <= negRem  ? negWord(acc[2*W-1:W]) : acc[2*W-1:W];
                    acc[W-1:0]   <= negMain ? negWord(acc[W-1:0])   : acc[W-1:0];
                end
            end else if (negMain) begin
                acc <= negDword(acc);
            end
        end
    end

    assign result  = acc;
    assign divZero = zeroDivisor;

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EX-stage ALU. Owns all
// muldiv writes into HiLo and stalls the pipeline front on collisions.
//   Clock  system clock, rising edge
//   Reset  synchronous, active-low reset
//   bus    muldiv_if.slave: Start/Flush/Op/OpA/OpB/HiLoAccess in,
//          Stall/Busy/HiLoEn/HiLoWrite/DivByZero out
// Timing: Start accepted in cycle k -> RUN k+1..k+32, FIX k+33,
// DONE (HiLoEn) k+34, IDLE k+35.
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic     Clock,
    input  logic     Reset,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(ITER);

    state_t              state;
    state_t              stateNext;
    logic [CNT_W-1:0]    count;
    logic                load;
    logic                step;
    logic                fix;
    logic                busy;
    logic                hiLoEn;
    opCode_t             op;
    logic [2*WIDTH-1:0]  coreResult;
    logic                coreDivZero;

    assign op = opCode_t'(bus.Op);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            if (load) begin
                count <= CNT_W'(ITER - 1);
            end else if (step) begin
                count <= count - 1'b1;
            end
        end
    end

    // Flush only qualifies a new Start; an operation already running belongs
    // to a committed instruction and always completes.
    always_comb begin
        stateNext = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.Start && !bus.Flush) begin
                    load      = 1'b1;
                    stateNext = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (count == '0) begin
                    stateNext = S_FIX;
                end
            end
            S_FIX: begin
                fix       = 1'b1;
                stateNext = S_DONE;
            end
            S_DONE: begin
                stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    muldiv_core u_core (
        .Clock    (Clock),
        .load     (load),
        .step     (step),
        .fix      (fix),
        .isDiv    (opIsDiv(op)),
        .isSigned (opIsSigned(op)),
        .opA      (bus.OpA),
        .opB      (bus.OpB),
        .result   (coreResult),
        .divZero  (coreDivZero)
    );

    assign busy   = (state != S_IDLE);
    assign hiLoEn = (state == S_DONE);

    // Stall covers DONE as well: HiLo only takes the new value at the end of
    // DONE, so an mfhi/mflo in that cycle would read the stale contents.
    assign bus.Busy      = busy;
    assign bus.Stall     = busy & (bus.Start | bus.HiLoAccess);
    assign bus.HiLoEn    = hiLoEn;
    assign bus.HiLoWrite = hiLoEn ? coreResult : '0;
    assign bus.DivByZero = hiLoEn & coreDivZero;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    muldiv_if bus();

    muldiv_sequencer dut (
        .Clock (clk),
        .Reset (rstN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nTests  = 0;
    int nFail   = 0;
    int enCount = 0;

    typedef struct {
        logic [63:0] hiLo;
        logic        dbz;
        int          due;
    } expect_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hiLo;
        logic        dbz;
    } vec_t;

    expect_t sbq[$];
    expect_t exp1;
    vec_t    vecs[14];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int req);
        nTests++;
        if (act != req) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard side: every HiLo write must match the oldest pending result.
    always @(negedge clk) begin
        if (bus.HiLoEn === 1'b1) begin
            enCount++;
            if (sbq.size() == 0) begin
                nTests++;
                nFail++;
                $display("FAIL unexpected_hiloen: HiLoEn at cycle %0d, no result pending", cyc);
            end else begin
                exp1 = sbq.pop_front();
                check64("hilo_data", bus.HiLoWrite, exp1.hiLo);
                check1("div_by_zero", bus.DivByZero, exp1.dbz);
                checkInt("hiloen_cycle", cyc, exp1.due);
            end
        end else if (bus.DivByZero !== 1'b0) begin
            nTests++;
            nFail++;
            $display("FAIL dbz_without_en: DivByZero %b at cycle %0d, expected 0", bus.DivByZero, cyc);
        end
    end

    // Advance to #1 after the rising edge that starts cycle t.
    task automatic goCycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (bus.Busy !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check1(name, bus.Busy, 1'b0);
    endtask

    task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.OpA   = a;
        bus.OpB   = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int snap;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0};
        vecs[3]  = '{OP_MULT,  32'h00000005, 32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFE2, 1'b0};
        vecs[4]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 1'b0};
        vecs[5]  = '{OP_MULT,  32'h00000000, 32'h12345678, 64'h00000000_00000000, 1'b0};
        vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0};
        vecs[7]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 64'h00000001_00000003, 1'b0};
        vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
        vecs[9]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 64'h00001234_FFFFFFFF, 1'b1};
        vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF, 1'b1};
        vecs[11] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0};
        vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 1'b0};
        vecs[13] = '{OP_DIV,   32'h00000064, 32'h00000007, 64'h00000002_0000000E, 1'b0};

        bus.Start      = 1'b0;
        bus.Flush      = 1'b0;
        bus.Op         = 2'b00;
        bus.OpA        = '0;
        bus.OpB        = '0;
        bus.HiLoAccess = 1'b0;
        rstN           = 1'b0;

        // Reset state, with Start and HiLoAccess presented during reset
        goCycle(2);
        startOp(OP_MULTU, 32'h5, 32'h6);
        bus.HiLoAccess = 1'b1;
        goCycle(3);
        #1;
        check1("reset_busy", bus.Busy, 1'b0);
        check1("reset_stall", bus.Stall, 1'b0);
        check1("reset_hiloen", bus.HiLoEn, 1'b0);
        check1("reset_dbz", bus.DivByZero, 1'b0);
        check64("reset_hilowrite", bus.HiLoWrite, 64'h0);
        bus.Start      = 1'b0;
        bus.HiLoAccess = 1'b0;
        rstN           = 1'b1;
        goCycle(5);

        // Table-driven operations
        for (int i = 0; i < 14; i++) begin
            k = cyc;
            startOp(vecs[i].op, vecs[i].a, vecs[i].b);
            sbq.push_back('{vecs[i].hiLo, vecs[i].dbz, k + 34});
            goCycle(k + 1);
            bus.Start = 1'b0;
            check1("vec_accept", bus.Busy, 1'b1);
            waitIdle("vec_idle");
        end

        // Latency and HiLoAccess stall, including the DONE cycle
        goCycle(cyc + 1);
        k = cyc;
        startOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        sbq.push_back('{64'hFFFFFFFE_00000001, 1'b0, k + 34});
        goCycle(k + 1);
        bus.Start = 1'b0;
        goCycle(k + 5);
        bus.HiLoAccess = 1'b1;
        #1;
        check1("stall_hla_run", bus.Stall, 1'b1);
        bus.HiLoAccess = 1'b0;
        #1;
        check1("no_stall_idle_bus", bus.Stall, 1'b0);
        goCycle(k + 33);
        #1;
        check1("hiloen_not_fix", bus.HiLoEn, 1'b0);
        goCycle(k + 34);
        bus.HiLoAccess = 1'b1;
        #1;
        check1("stall_hla_done", bus.Stall, 1'b1);
        check1("hiloen_done", bus.HiLoEn, 1'b1);
        goCycle(k + 35);
        #1;
        check1("stall_released", bus.Stall, 1'b0);
        check1("idle_after_done", bus.Busy, 1'b0);
        bus.HiLoAccess = 1'b0;

        // Back-to-back: second Start held from k+10 until accepted at k+35
        goCycle(cyc + 1);
        k = cyc;
        startOp(OP_MULT, 32'hFFFFFFFD, 32'h00000007);
        sbq.push_back('{64'hFFFFFFFF_FFFFFFEB, 1'b0, k + 34});
        goCycle(k + 1);
        bus.Start = 1'b0;
        goCycle(k + 10);
        startOp(OP_DIVU, 32'h00000007, 32'h00000002);
        sbq.push_back('{64'h00000001_00000003, 1'b0, k + 69});
        snap = 0;
        for (int t = k + 10; t <= k + 34; t++) begin
            goCycle(t);
            #1;
            if (bus.Stall !== 1'b1) snap++;
        end
        checkInt("stall_held_cycles_low", snap, 0);
        goCycle(k + 35);
        #1;
        check1("b2b_stall_release", bus.Stall, 1'b0);
        goCycle(k + 36);
        bus.Start = 1'b0;
        check1("b2b_second_accept", bus.Busy, 1'b1);
        waitIdle("b2b_idle");

        // Reset in the middle of a run discards the operation
        goCycle(cyc + 1);
        k = cyc;
        startOp(OP_DIV, 32'h00000064, 32'h00000007);
        goCycle(k + 1);
        bus.Start = 1'b0;
        goCycle(k + 12);
        check1("busy_before_reset", bus.Busy, 1'b1);
        rstN = 1'b0;
        goCycle(k + 13);
        bus.HiLoAccess = 1'b1;
        #1;
        check1("midrun_reset_busy", bus.Busy, 1'b0);
        check1("midrun_reset_stall", bus.Stall, 1'b0);
        rstN = 1'b1;
        bus.HiLoAccess = 1'b0;
        snap = enCount;
        goCycle(k + 60);
        checkInt("no_hiloen_after_reset", enCount, snap);

        // Start with Flush in IDLE is ignored
        k = cyc;
        startOp(OP_MULT, 32'h3, 32'h4);
        bus.Flush = 1'b1;
        goCycle(k + 1);
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        check1("flush_ignored", bus.Busy, 1'b0);
        goCycle(k + 3);
        check1("flush_still_idle", bus.Busy, 1'b0);

        // Flush while busy does not abort
        k = cyc;
        startOp(OP_MULTU, 32'h00000003, 32'h00000004);
        sbq.push_back('{64'h00000000_0000000C, 1'b0, k + 34});
        goCycle(k + 1);
        bus.Start = 1'b0;
        goCycle(k + 3);
        bus.Flush = 1'b1;
        goCycle(k + 6);
        bus.Flush = 1'b0;
        check1("flush_busy_continues", bus.Busy, 1'b1);
        waitIdle("flush_busy_idle");

        goCycle(cyc + 2);
        checkInt("scoreboard_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU. Sits beside the EX-stage ALU and owns all writes of muldiv results into the HiLo register.
- Takes forwarded operands from EX and iterates one bit per cycle: shift-add for multiply, restoring division for divide.
- Writes the 64-bit result into HiLo with a one-cycle enable pulse.
- Stalls the front of the pipeline while a new muldiv op or any HiLo access collides with an in-flight operation.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; HiLo is 2*WIDTH.
- ITER, 32, iteration count. Must equal WIDTH.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  EX holds a valid muldiv instruction this cycle.
- Flush  in  1  EX instruction is squashed; qualifies Start.
- Op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- OpA  in  32  forwarded rs value (multiplicand or dividend).
- OpB  in  32  forwarded rt value (multiplier or divisor).
- HiLoAccess  in  1  EX instruction is mfhi, mflo, mthi or mtlo.
- Stall  out  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- Busy  out  1  state is not IDLE.
- HiLoEn  out  1  one-cycle HiLo write strobe.
- HiLoWrite  out  64  result as {Hi, Lo}.
- DivByZero  out  1  asserted together with HiLoEn when a divide had OpB == 0.

Behaviour:
- Reset (Reset == 0 at a rising edge):
  - State goes to IDLE.
  - Stall, Busy, HiLoEn and DivByZero are 0; HiLoWrite is 0.
  - An in-flight operation is discarded and no HiLo write occurs.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - Start & ~Flush captures Op, OpA and OpB.
  - For signed ops, registers |OpA|, |OpB| and the two sign bits. Unsigned ops use the raw values.
  - Loads counter to ITER-1, then goes to RUN.
  - Start with Flush = 1 is ignored.
- RUN: one iteration per cycle. When the counter reaches 0, go to FIX.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper product half; then shift the 64-bit accumulator right by 1.
  - Divide: shift {rem, quot} left by 1. Trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quotient LSB to 1.
- FIX: apply the sign fixup, then go to DONE.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- DONE:
  - HiLoEn = 1 for exactly this cycle.
  - HiLoWrite = {product[63:32], product[31:0]}, or {remainder, quotient}.
  - Next state is IDLE.
- Latency: if Start is accepted in cycle k, RUN covers k+1..k+32, FIX is k+33, DONE (HiLoEn) is k+34, and IDLE is k+35. Total is fixed at 34 cycles after acceptance.
- Stall (combinational) = Busy & (Start | HiLoAccess). It includes DONE, because HiLo only updates at the end of DONE.
  - Start while Busy is not captured. EX re-presents it after the stall releases, and it is accepted in the first IDLE cycle.
- Divide by zero (either sign):
  - Lo = 0xFFFFFFFF, Hi = OpA (the original value, not the absolute value).
  - DivByZero = 1 in the DONE cycle.
  - Takes the same latency as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0 (natural wrap, no trap).
- HiLo write conflict: the ALU mthi/mtlo path never writes HiLo in the same cycle as HiLoEn, because Stall blocks HiLoAccess while Busy. At the HiLo register the two enables are ORed, and this block's data is muxed in when HiLoEn = 1.
- Flush while Busy does not abort: the operation was issued by an earlier, committed instruction.

Decomposition:
- Shared package muldiv_pkg:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - State encoding: S_IDLE, S_RUN, S_FIX, S_DONE.
  - Constants WIDTH and ITER.
- One sub-module, muldiv_core: the iterative datapath (accumulator, remainder/quotient registers, add/subtract, sign fixup). Controlled by load, step, fix and is_div strobes.
- The FSM, counter and stall logic stay in muldiv_sequencer.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF accepted at k -> HiLoEn = 1 only at k+34, HiLoWrite = 0xFFFFFFFE_00000001, DivByZero = 0.
- MULT 0xFFFFFFFD (-3) × 7 -> HiLoWrite = 0xFFFFFFFF_FFFFFFEB. MULT 0x80000000 × 0x80000000 -> 0x40000000_00000000.
- DIV -7 / 2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. DIVU 7 / 2 -> Lo = 3, Hi = 1. DIV 0x80000000 / -1 -> Lo = 0x80000000, Hi = 0.
- DIVU 0x1234 / 0 -> at k+34: Lo = 0xFFFFFFFF, Hi = 0x1234, DivByZero = 1, HiLoEn = 1.
- Stall and back-to-back ops:
  - HiLoAccess at k+5 and at k+34 -> Stall = 1 in both cycles; at k+35 -> Stall = 0.
  - Second Start held from k+10 -> Stall = 1 through k+34, accepted at k+35, its HiLoEn at k+69.
- Reset and Flush:
  - Reset = 0 at k+12 -> IDLE at k+13, Busy = 0, no HiLoEn ever.
  - Start with Flush = 1 in IDLE -> Busy stays 0.
